// File: rtl/baccarat_pkg.sv
// Shared Baccarat types and tableau constants.
// card_value is also used by the datapath to score raw card codes.
package baccarat_pkg;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] STAND_MIN   = 4'd6;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEAL_P1   = 4'd1,
    DEAL_D1   = 4'd2,
    DEAL_P2   = 4'd3,
    DEAL_D2   = 4'd4,
    CHECK_NAT = 4'd5,
    DRAW_P3   = 4'd6,
    CHECK_D3  = 4'd7,
    DRAW_D3   = 4'd8,
    DONE      = 4'd9
  } state_t;

  // Face cards (10, J, Q, K encoded 10..13) count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] raw);
    return (raw > 4'd9) ? 4'd0 : raw;
  endfunction

endpackage

// File: rtl/baccarat_controller_banker_draw_rule.sv
// Banker third-card decision once the player has drawn a third card.
// Scores of 7 and above (or out-of-range values) always stand.
module banker_draw_rule (
  input  logic [3:0] dscore_i,
  input  logic [3:0] p3v_i,
  output logic       draw_o
);

  always_comb begin
    draw_o = 1'b0;
    case (dscore_i)
      4'd0, 4'd1, 4'd2: draw_o = 1'b1;
      4'd3:             draw_o = (p3v_i != 4'd8);
      4'd4:             draw_o = (p3v_i >= 4'd2) && (p3v_i <= 4'd7);
      4'd5:             draw_o = (p3v_i >= 4'd4) && (p3v_i <= 4'd7);
      4'd6:             draw_o = (p3v_i >= 4'd6) && (p3v_i <= 4'd7);
      default:          draw_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_controller.sv
// Baccarat round sequencer: deals four cards, applies the tableau rules,
// then shows the winner. One state step per slow_clock rising edge.
//
// state     | meaning
// IDLE      | waiting, all outputs low
// DEAL_P1   | load player card 1
// DEAL_D1   | load dealer card 1
// DEAL_P2   | load player card 2
// DEAL_D2   | load dealer card 2
// CHECK_NAT | naturals / player stand decision
// DRAW_P3   | load player card 3
// CHECK_D3  | banker decision using player third card
// DRAW_D3   | load dealer card 3
// DONE      | win lights valid, held until reset
module baccarat_controller
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic [3:0] state_dbg
);

  state_t state_q, state_d;
  logic   banker_draw;

  banker_draw_rule u_banker_draw_rule (
    .dscore_i (dscore),
    .p3v_i    (card_value(pcard3)),
    .draw_o   (banker_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:      state_d = DEAL_P1;
      DEAL_P1:   state_d = DEAL_D1;
      DEAL_D1:   state_d = DEAL_P2;
      DEAL_P2:   state_d = DEAL_D2;
      DEAL_D2:   state_d = CHECK_NAT;
      CHECK_NAT: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) state_d = DONE;
        else if (pscore < STAND_MIN)                            state_d = DRAW_P3;
        else if (dscore < STAND_MIN)                            state_d = DRAW_D3;
        else                                                    state_d = DONE;
      end
      DRAW_P3:   state_d = CHECK_D3;
      CHECK_D3:  state_d = banker_draw ? DRAW_D3 : DONE;
      DRAW_D3:   state_d = DONE;
      DONE:      state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (state_q)
      DEAL_P1: load_pcard1 = 1'b1;
      DEAL_D1: load_dcard1 = 1'b1;
      DEAL_P2: load_pcard2 = 1'b1;
      DEAL_D2: load_dcard2 = 1'b1;
      DRAW_P3: load_pcard3 = 1'b1;
      DRAW_D3: load_dcard3 = 1'b1;
      DONE: begin
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_baccarat_controller.sv
// Self-checking bench for baccarat_controller against a tableau-level model.
module tb_baccarat_controller;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pscore = 4'd0, dscore = 4'd0, pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int path_q[$];

  baccarat_controller dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .state_dbg        (state_dbg)
  );

  always #5 slow_clock = ~slow_clock;

  // Player third-card values (bit index) for which the banker draws, by banker score 3..6.
  function automatic bit banker_draws(int ds, int pv);
    bit [9:0] mask;
    if (ds <= 2) return 1'b1;
    case (ds)
      3:       mask = 10'b10_1111_1111;
      4:       mask = 10'b00_1111_1100;
      5:       mask = 10'b00_1111_0000;
      6:       mask = 10'b00_1100_0000;
      default: mask = 10'b0;
    endcase
    return mask[pv];
  endfunction

  // Expected state sequence for a whole round, starting at IDLE just after reset.
  task automatic build_path(int ps, int ds, int pc3);
    int pv;
    pv = (pc3 > 9) ? 0 : pc3;
    path_q = '{0, 1, 2, 3, 4, 5};
    if (ps >= 8 || ds >= 8) path_q.push_back(9);
    else if (ps <= 5) begin
      path_q.push_back(6);
      path_q.push_back(7);
      if (banker_draws(ds, pv)) path_q.push_back(8);
      path_q.push_back(9);
    end else begin
      if (ds <= 5) path_q.push_back(8);
      path_q.push_back(9);
    end
  endtask

  // Expected {lp1,lp2,lp3,ld1,ld2,ld3,pwin,dwin} for a state and the current scores.
  function automatic logic [7:0] exp_outs(int st, int ps, int ds);
    case (st)
      1: return 8'b1000_0000;
      2: return 8'b0001_0000;
      3: return 8'b0100_0000;
      4: return 8'b0000_1000;
      6: return 8'b0010_0000;
      8: return 8'b0000_0100;
      9: return {6'b0, ps >= ds, ds >= ps};
      default: return 8'b0;
    endcase
  endfunction

  function automatic logic [7:0] act_outs();
    return {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
            load_dcard3, player_win_light, dealer_win_light};
  endfunction

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic apply_reset();
    resetb = 1'b0;
    step();
    resetb = 1'b1;
  endtask

  // Plays one round from reset; checks every state and output against the model.
  task automatic play_round(string name, int ps, int ds, int pc3);
    logic [7:0] e;
    pscore = 4'(ps); dscore = 4'(ds); pcard3 = 4'(pc3);
    build_path(ps, ds, pc3);
    apply_reset();
    foreach (path_q[i]) begin
      if (i > 0) step();
      total++;
      if (state_dbg !== 4'(path_q[i])) begin
        bad++;
        $display("FAIL %s step%0d state: got %0d want %0d (ps=%0d ds=%0d pc3=%0d)",
                 name, i, state_dbg, path_q[i], ps, ds, pc3);
      end
      e = exp_outs(path_q[i], ps, ds);
      total++;
      if (act_outs() !== e) begin
        bad++;
        $display("FAIL %s step%0d outs: got %b want %b (ps=%0d ds=%0d pc3=%0d)",
                 name, i, act_outs(), e, ps, ds, pc3);
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    step();
    total++;
    if (state_dbg !== 4'd0 || act_outs() !== 8'b0) begin
      bad++;
      $display("FAIL reset: state=%0d outs=%b want 0/00000000", state_dbg, act_outs());
    end
    play_round("reset_walk", 5, 5, 7);
  endtask

  task automatic test_natural();
    play_round("natural", 8, 3, 8);
  endtask

  task automatic test_player_stands();
    play_round("stand_draw", 7, 4, 0);
    dscore = 4'd7;
    #1;
    total++;
    if (state_dbg !== 4'd9 || player_win_light !== 1'b1 || dealer_win_light !== 1'b1) begin
      bad++;
      $display("FAIL tie: state=%0d pw=%b dw=%b want 9/1/1", state_dbg, player_win_light,
               dealer_win_light);
    end
  endtask

  task automatic test_banker_table();
    int cards[5] = '{2, 4, 6, 8, 12};
    for (int ds = 3; ds <= 6; ds++)
      foreach (cards[k]) play_round("banker_table", 3, ds, cards[k]);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      play_round("random", $urandom_range(9), $urandom_range(9), $urandom_range(13));
  endtask

  task automatic test_mid_reset();
    pscore = 4'd3; dscore = 4'd3; pcard3 = 4'd5;
    apply_reset();
    for (int i = 0; i < 6; i++) step();
    total++;
    if (state_dbg !== 4'd6) begin
      bad++;
      $display("FAIL mid_reset_setup: state=%0d want 6", state_dbg);
    end
    resetb = 1'b0;
    step();
    total++;
    if (state_dbg !== 4'd0 || act_outs() !== 8'b0) begin
      bad++;
      $display("FAIL mid_reset: state=%0d outs=%b want 0/00000000", state_dbg, act_outs());
    end
    resetb = 1'b1;
    step();
    total++;
    if (state_dbg !== 4'd1 || act_outs() !== 8'b1000_0000) begin
      bad++;
      $display("FAIL mid_reset_restart: state=%0d outs=%b want 1/10000000", state_dbg,
               act_outs());
    end
  endtask

  task automatic test_done_hold();
    play_round("done_hold", 2, 6, 9);
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (state_dbg !== 4'd9 || act_outs() !== exp_outs(9, 2, 6)) begin
        bad++;
        $display("FAIL done_hold edge%0d: state=%0d outs=%b want 9/%b", i, state_dbg,
                 act_outs(), exp_outs(9, 2, 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_player_stands();
    test_banker_table();
    test_random();
    test_mid_reset();
    test_done_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
